// File: rtl/aes256_inv_cipher.sv
// Iterative AES-256 inverse cipher: one round per clock, round keys latched
// locally so the key producer may change its outputs while a block is in flight.
package aes256_pkg;
  typedef logic [14:0][127:0] round_keys_t;
endpackage

module aes256_inv_cipher
  import aes256_pkg::*;
#(
  parameter int NUM_ROUNDS = 14,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  round_keys_t           round_keys_i,
  input  logic                  round_keys_valid_i,
  input  logic [DATA_WIDTH-1:0] ct_i,
  input  logic                  ct_valid_i,
  output logic                  ct_ready_o,
  output logic [DATA_WIDTH-1:0] pt_o,
  output logic                  pt_valid_o,
  input  logic                  pt_ready_i
);

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0e*a, 0b*a, 0d*a, 09*a} built from the xtime chain.
  function automatic logic [31:0] mulv(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  // Byte k lives at bits 127-8k; column c holds bytes 4c..4c+3 (row 0 first).
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = INV_SBOX[s[127-8*(4*((c-row+4)%4)+row) -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  m0, m1, m2, m3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      m0 = mulv(s[127-32*c -: 8]);
      m1 = mulv(s[119-32*c -: 8]);
      m2 = mulv(s[111-32*c -: 8]);
      m3 = mulv(s[103-32*c -: 8]);
      // Fields: [31:24]=0e [23:16]=0b [15:8]=0d [7:0]=09
      r[127-32*c -: 8] = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
      r[119-32*c -: 8] = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
      r[111-32*c -: 8] = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
      r[103-32*c -: 8] = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
    end
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   st_q, st_d;
  logic [DATA_WIDTH-1:0]   pt_q, pt_d;
  logic                    ptv_q, ptv_d;
  logic [3:0]              rnd_q, rnd_d;
  logic                    keys_loaded_q;
  round_keys_t             key_q;
  round_keys_t             eff_key;
  logic [DATA_WIDTH-1:0]   dec;
  logic                    key_load;

  assign key_load   = (state_q == IDLE) && round_keys_valid_i;
  assign eff_key    = round_keys_valid_i ? round_keys_i : key_q;
  assign ct_ready_o = resetn && (state_q == IDLE) && (keys_loaded_q || round_keys_valid_i);
  assign pt_o       = pt_q;
  assign pt_valid_o = ptv_q;

  // Key file is deliberately left out of reset; keys_loaded gates its use.
  always_ff @(posedge clk) begin
    if (key_load) key_q <= round_keys_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      st_q          <= '0;
      pt_q          <= '0;
      ptv_q         <= 1'b0;
      rnd_q         <= '0;
      keys_loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      ptv_q   <= ptv_d;
      rnd_q   <= rnd_d;
      if (key_load) keys_loaded_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    pt_d    = pt_q;
    ptv_d   = ptv_q;
    rnd_d   = rnd_q;
    dec     = inv_shift_sub(st_q) ^ key_q[rnd_q];
    case (state_q)
      IDLE: begin
        if (ct_valid_i && ct_ready_o) begin
          st_d    = ct_i ^ eff_key[NUM_ROUNDS];
          rnd_d   = 4'(NUM_ROUNDS - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == 4'd0) begin
          pt_d    = dec;
          ptv_d   = 1'b1;
          state_d = OUT;
        end else begin
          st_d  = inv_mix(dec);
          rnd_d = rnd_q - 4'd1;
        end
      end
      OUT: begin
        if (pt_ready_i) begin
          ptv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes256_inv_cipher.sv
// Directed bench for aes256_inv_cipher; keys and extra ciphertexts come from a
// forward AES-256 reference written here.
module tb_aes256_inv_cipher;
  import aes256_pkg::*;

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEYF = {256{1'b1}};
  localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2   = 128'h0123456789abcdeffedcba9876543210;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  round_keys_t rk = '0;
  logic        rkv = 1'b0;
  logic [127:0] ct = '0;
  logic        ctv = 1'b0;
  logic        ct_ready;
  logic [127:0] pt;
  logic        ptv;
  logic        ptr = 1'b0;

  int checks = 0;
  int errors = 0;
  round_keys_t rk1, rkf;

  aes256_inv_cipher dut (
    .clk(clk), .resetn(resetn),
    .round_keys_i(rk), .round_keys_valid_i(rkv),
    .ct_i(ct), .ct_valid_i(ctv), .ct_ready_o(ct_ready),
    .pt_o(pt), .pt_valid_o(ptv), .pt_ready_i(ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic round_keys_t expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    round_keys_t r;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input round_keys_t k);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = p ^ k[0];
    for (int r = 1; r < 15; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[127-8*(4*c+row) -: 8] = SBOX[s[127-8*(4*((c+row)%4)+row) -: 8]];
      s = t;
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = s ^ k[r];
    end
    return s;
  endfunction

  // Present a ciphertext until accepted; n is the number of cycles waited.
  task automatic send(input logic [127:0] c, output int n);
    ct = c; ctv = 1'b1; #1;
    n = 0;
    while (ct_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    ctv = 1'b0;
  endtask

  task automatic wait_pt(output int n);
    n = 0;
    while (ptv !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rkv = 1'b0; ctv = 1'b0; ptr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ct_ready !== 1'b0) begin errors++; $display("FAIL reset_ct_ready: got %b exp 0", ct_ready); end
    checks++; if (ptv !== 1'b0) begin errors++; $display("FAIL reset_pt_valid: got %b exp 0", ptv); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL reset_pt: got %h exp 0", pt); end
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if (ct_ready !== 1'b0) begin errors++; $display("FAIL nokey_ct_ready: got %b exp 0", ct_ready); end
  endtask

  task automatic test_c3();
    int n;
    rk = rk1; rkv = 1'b1; ptr = 1'b1;
    ct = C3; ctv = 1'b1; #1;
    checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL c3_ready: got %b exp 1", ct_ready); end
    @(negedge clk);
    ctv = 1'b0;
    wait_pt(n);
    checks++; if (n != 14) begin errors++; $display("FAIL c3_latency: got %0d exp 14", n); end
    checks++; if (pt !== P0) begin errors++; $display("FAIL c3_pt: got %h exp %h", pt, P0); end
    @(negedge clk); #1;
    checks++; if (ptv !== 1'b0) begin errors++; $display("FAIL c3_handshake: got %b exp 0", ptv); end
    checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL c3_ready_after: got %b exp 1", ct_ready); end
    rkv = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] held;
    ptr = 1'b0;
    send(C3, n);
    checks++; if (n != 0) begin errors++; $display("FAIL bp_accept_wait: got %0d exp 0", n); end
    wait_pt(n);
    checks++; if (n != 14) begin errors++; $display("FAIL bp_latency: got %0d exp 14", n); end
    held = pt;
    checks++; if (held !== P0) begin errors++; $display("FAIL bp_pt: got %h exp %h", held, P0); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pt !== P0 || ptv !== 1'b1 || ct_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got pt=%h v=%b rdy=%b exp pt=%h v=1 rdy=0", i, pt, ptv, ct_ready, P0);
      end
    end
    ptr = 1'b1;
    @(negedge clk); #1;
    ptr = 1'b0;
    checks++; if (ptv !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b exp 0", ptv); end
    checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", ct_ready); end
  endtask

  task automatic test_key_change();
    int n;
    logic [127:0] c2;
    c2 = encrypt(P2, rkf);
    ptr = 1'b1;
    send(C3, n);
    repeat (3) @(negedge clk);
    rk = rkf; rkv = 1'b1;
    @(negedge clk);
    rkv = 1'b0;
    wait_pt(n);
    checks++; if (n >= 60) begin errors++; $display("FAIL kc_timeout1: got %0d exp <60", n); end
    checks++; if (pt !== P0) begin errors++; $display("FAIL kc_old_keys: got %h exp %h", pt, P0); end
    @(negedge clk);
    rkv = 1'b1;
    @(negedge clk);
    rkv = 1'b0;
    send(c2, n);
    wait_pt(n);
    checks++; if (n != 14) begin errors++; $display("FAIL kc_latency2: got %0d exp 14", n); end
    checks++; if (pt !== P2) begin errors++; $display("FAIL kc_new_keys: got %h exp %h", pt, P2); end
    @(negedge clk);
  endtask

  task automatic test_no_keys();
    int n;
    do_reset();
    rk = rk1; rkv = 1'b0; ptr = 1'b1;
    ct = C3; ctv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (ct_ready !== 1'b0 || ptv !== 1'b0) begin errors++; $display("FAIL nk_wait[%0d]: got rdy=%b v=%b exp 0", i, ct_ready, ptv); end
      @(negedge clk);
    end
    rkv = 1'b1; #1;
    checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL nk_same_cycle_ready: got %b exp 1", ct_ready); end
    @(negedge clk);
    rkv = 1'b0; ctv = 1'b0;
    wait_pt(n);
    checks++; if (n != 14) begin errors++; $display("FAIL nk_latency: got %0d exp 14", n); end
    checks++; if (pt !== P0) begin errors++; $display("FAIL nk_pt: got %h exp %h", pt, P0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    ptr = 1'b1;
    send(C3, n);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ptv !== 1'b0 || pt !== 128'h0 || ct_ready !== 1'b0) begin
      errors++; $display("FAIL rm_outputs: got v=%b pt=%h rdy=%b exp all 0", ptv, pt, ct_ready);
    end
    resetn = 1'b1;
    ctv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (ptv !== 1'b0 || ct_ready !== 1'b0) begin
        errors++; $display("FAIL rm_after[%0d]: got v=%b rdy=%b exp 0", i, ptv, ct_ready);
      end
    end
    ctv = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, nacc, npt;
    int acc_t [4];
    logic drop;
    cyc = 0; nacc = 0; npt = 0; drop = 1'b0;
    rk = rk1; rkv = 1'b1; ptr = 1'b1;
    ct = C3; ctv = 1'b1; #1;
    while (npt < 4 && cyc < 200) begin
      if (ctv && ct_ready && nacc < 4) begin
        acc_t[nacc] = cyc; nacc++;
        if (nacc == 4) drop = 1'b1;
      end
      if (ptv === 1'b1) begin
        npt++;
        checks++; if (pt !== P0) begin errors++; $display("FAIL b2b_pt[%0d]: got %h exp %h", npt, pt, P0); end
      end
      @(negedge clk); #1; cyc++;
      if (drop) begin ctv = 1'b0; drop = 1'b0; end
    end
    rkv = 1'b0;
    checks++; if (npt != 4) begin errors++; $display("FAIL b2b_count: got %0d exp 4", npt); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (i < nacc && acc_t[i] - acc_t[i-1] != 16) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d exp 16", i, acc_t[i] - acc_t[i-1]);
      end else if (i >= nacc) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got missing accept exp 16", i);
      end
    end
  endtask

  initial begin
    rk1 = expand(KEY1);
    rkf = expand(KEYF);
    @(negedge clk);
    test_reset();
    test_c3();
    test_backpressure();
    test_key_change();
    test_no_keys();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
